assertion_result_collector: RTL and testbench



---
 rtl/assertion_result_collector.sv | 174 +++++++++++++++++
 tb/tb_assertion_result_collector.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/assertion_result_collector.sv
// Aggregates SVA checker outputs into pass/fail counters and an active count,
// and queues timestamped failure events. Define ASSERTION_COLLECTOR_SATURATE_EN for saturating counters.
module assertion_result_collector #(
    parameter int NUM_CHECKERS = 4,
    parameter int CNT_W        = 16,
    parameter int TS_W         = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int ID_W         = (NUM_CHECKERS > 1) ? $clog2(NUM_CHECKERS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CHECKERS-1:0] chk_pass,
    input  logic [NUM_CHECKERS-1:0] chk_fail,
    input  logic [NUM_CHECKERS-1:0] chk_active,
    input  logic                    clear,
    input  logic [ID_W-1:0]         rd_sel,
    output logic [CNT_W-1:0]        rd_pass_cnt,
    output logic [CNT_W-1:0]        rd_fail_cnt,
    output logic [ID_W:0]           active_cnt,
    output logic                    any_fail,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [ID_W-1:0]         evt_id,
    output logic [TS_W-1:0]         evt_ts,
    output logic                    evt_dropped
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [TS_W-1:0]         ts_q, ts_d;
    logic [CNT_W-1:0]        pass_cnt_q [NUM_CHECKERS];
    logic [CNT_W-1:0]        pass_cnt_d [NUM_CHECKERS];
    logic [CNT_W-1:0]        fail_cnt_q [NUM_CHECKERS];
    logic [CNT_W-1:0]        fail_cnt_d [NUM_CHECKERS];
    logic [NUM_CHECKERS-1:0] pending_q, pending_d;
    logic [TS_W-1:0]         pend_ts_q [NUM_CHECKERS];
    logic [TS_W-1:0]         pend_ts_d [NUM_CHECKERS];
    logic [AW:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]             rd_ptr_q, rd_ptr_d;
    logic [ID_W:0]           active_cnt_q, active_cnt_d;
    logic                    any_fail_q, any_fail_d;
    logic                    dropped_q, dropped_d;

    logic [ID_W-1:0]         fifo_id_q [FIFO_DEPTH];
    logic [TS_W-1:0]         fifo_ts_q [FIFO_DEPTH];

    logic [AW:0]             fifo_count;
    logic                    fifo_full;
    logic                    pop;
    logic                    push;
    logic                    push_wr;
    logic [ID_W-1:0]         push_sel;
    logic [NUM_CHECKERS-1:0] push_onehot;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
`ifdef ASSERTION_COLLECTOR_SATURATE_EN
        cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
`else
        cnt_inc = cnt + CNT_W'(1);
`endif
    endfunction

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign evt_valid  = (fifo_count != '0);
    assign pop        = evt_valid && evt_ready;

    // Lowest-index pending checker wins; a same-cycle pop frees a slot in a full FIFO.
    always_comb begin
        push_sel = '0;
        for (int i = NUM_CHECKERS - 1; i >= 0; i--) begin
            if (pending_q[i]) push_sel = ID_W'(i);
        end
    end

    assign push    = (|pending_q) && (!fifo_full || pop);
    assign push_wr = push && !clear;

    always_comb begin
        for (int i = 0; i < NUM_CHECKERS; i++) begin
            push_onehot[i] = push && (push_sel == ID_W'(i));
        end
    end

    always_comb begin
        ts_d         = ts_q + TS_W'(1);
        pending_d    = pending_q & ~push_onehot;
        wr_ptr_d     = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        any_fail_d   = any_fail_q | (|chk_fail);
        dropped_d    = dropped_q;
        active_cnt_d = '0;
        for (int i = 0; i < NUM_CHECKERS; i++) begin
            active_cnt_d = active_cnt_d + (ID_W+1)'(chk_active[i]);
        end
        for (int i = 0; i < NUM_CHECKERS; i++) begin
            pass_cnt_d[i] = pass_cnt_q[i];
            fail_cnt_d[i] = fail_cnt_q[i];
            pend_ts_d[i]  = pend_ts_q[i];
            if (chk_fail[i]) begin
                fail_cnt_d[i] = cnt_inc(fail_cnt_q[i]);
                // A still-pending event that is not leaving this cycle blocks the new one.
                if (pending_q[i] && !push_onehot[i]) begin
                    dropped_d = 1'b1;
                end else begin
                    pending_d[i] = 1'b1;
                    pend_ts_d[i] = ts_q;
                end
            end else if (chk_pass[i]) begin
                pass_cnt_d[i] = cnt_inc(pass_cnt_q[i]);
            end
        end
        if (clear) begin
            ts_d       = '0;
            pending_d  = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            any_fail_d = 1'b0;
            dropped_d  = 1'b0;
            for (int i = 0; i < NUM_CHECKERS; i++) begin
                pass_cnt_d[i] = '0;
                fail_cnt_d[i] = '0;
                pend_ts_d[i]  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q         <= '0;
            pending_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            active_cnt_q <= '0;
            any_fail_q   <= 1'b0;
            dropped_q    <= 1'b0;
            for (int i = 0; i < NUM_CHECKERS; i++) begin
                pass_cnt_q[i] <= '0;
                fail_cnt_q[i] <= '0;
                pend_ts_q[i]  <= '0;
            end
        end else begin
            ts_q         <= ts_d;
            pending_q    <= pending_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            active_cnt_q <= active_cnt_d;
            any_fail_q   <= any_fail_d;
            dropped_q    <= dropped_d;
            for (int i = 0; i < NUM_CHECKERS; i++) begin
                pass_cnt_q[i] <= pass_cnt_d[i];
                fail_cnt_q[i] <= fail_cnt_d[i];
                pend_ts_q[i]  <= pend_ts_d[i];
            end
        end
    end

    // Storage needs no reset: the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_wr) begin
            fifo_id_q[wr_ptr_q[AW-1:0]] <= push_sel;
            fifo_ts_q[wr_ptr_q[AW-1:0]] <= pend_ts_q[push_sel];
        end
    end

    assign evt_id      = fifo_id_q[rd_ptr_q[AW-1:0]];
    assign evt_ts      = fifo_ts_q[rd_ptr_q[AW-1:0]];
    assign evt_dropped = dropped_q;
    assign any_fail    = any_fail_q;
    assign active_cnt  = active_cnt_q;
    assign rd_pass_cnt = (int'(rd_sel) < NUM_CHECKERS) ? pass_cnt_q[rd_sel] : '0;
    assign rd_fail_cnt = (int'(rd_sel) < NUM_CHECKERS) ? fail_cnt_q[rd_sel] : '0;

endmodule

// File: tb/tb_assertion_result_collector.sv
// Directed bench for assertion_result_collector; failure events are scored against an expected queue.
module tb_assertion_result_collector;

  localparam int N      = 4;
  localparam int CNT_W  = 4;
  localparam int TS_W   = 32;
  localparam int DEPTH  = 8;
  localparam int ID_W   = 2;
  localparam int EW     = ID_W + TS_W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    chk_pass = '0;
  logic [N-1:0]    chk_fail = '0;
  logic [N-1:0]    chk_active = '0;
  logic            clear = 1'b0;
  logic [ID_W-1:0] rd_sel = '0;
  logic [CNT_W-1:0] rd_pass_cnt;
  logic [CNT_W-1:0] rd_fail_cnt;
  logic [ID_W:0]   active_cnt;
  logic            any_fail;
  logic            evt_valid;
  logic            evt_ready = 1'b0;
  logic [ID_W-1:0] evt_id;
  logic [TS_W-1:0] evt_ts;
  logic            evt_dropped;

  int n_checks = 0;
  int n_fail   = 0;
  logic [TS_W-1:0] model_ts;
  logic [EW-1:0]   exp_q[$];
  logic            prev_stall;
  logic [EW-1:0]   prev_head;

  assertion_result_collector #(
    .NUM_CHECKERS(N), .CNT_W(CNT_W), .TS_W(TS_W), .FIFO_DEPTH(DEPTH), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .chk_pass(chk_pass), .chk_fail(chk_fail),
    .chk_active(chk_active), .clear(clear), .rd_sel(rd_sel),
    .rd_pass_cnt(rd_pass_cnt), .rd_fail_cnt(rd_fail_cnt), .active_cnt(active_cnt),
    .any_fail(any_fail), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_id(evt_id), .evt_ts(evt_ts), .evt_dropped(evt_dropped)
  );

  // clock / reset-aware timestamp reference
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     model_ts <= '0;
    else if (clear) model_ts <= '0;
    else            model_ts <= model_ts + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: pops on every handshake, also checks head stability while stalled
  always @(negedge clk) begin
    if (rst_n && evt_valid && prev_stall && !clear)
      check("head_stable", {evt_id, evt_ts}, prev_head);
    if (rst_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL evt_unexpected: observed id %0d ts %0d expected no event", evt_id, evt_ts);
      end else begin
        check("evt_head", {evt_id, evt_ts}, exp_q.pop_front());
      end
    end
    prev_stall = rst_n && evt_valid && !evt_ready;
    prev_head  = {evt_id, evt_ts};
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_fail(input logic [N-1:0] pattern, input bit expect_evt);
    chk_fail = pattern;
    if (expect_evt)
      for (int i = 0; i < N; i++)
        if (pattern[i]) exp_q.push_back({ID_W'(i), model_ts});
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_drain(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      step();
      cycles++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic read_cnt(input int sel, input logic [CNT_W-1:0] exp_pass,
                          input logic [CNT_W-1:0] exp_fail, input string tag);
    rd_sel = ID_W'(sel);
    #1;
    check({tag, "_pass_cnt"}, rd_pass_cnt, exp_pass);
    check({tag, "_fail_cnt"}, rd_fail_cnt, exp_fail);
  endtask

  initial begin
    int cyc;
    int guard;
    logic [N-1:0] pat;
    logic [CNT_W-1:0] sat_exp;

    #12;
    check("rst_evt_valid", evt_valid, 0);
    check("rst_any_fail", any_fail, 0);
    check("rst_dropped", evt_dropped, 0);
    rst_n = 1'b1;
    step();
    check("rst_active_cnt", active_cnt, 0);
    read_cnt(2, 0, 0, "rst");

    // single fail at ts=5: latency and content
    evt_ready = 1'b1;
    guard = 0;
    while (model_ts != 5 && guard < 20) begin step(); guard++; end
    drive_fail(4'b0100, 1);
    step();
    chk_fail = '0;
    check("lat_t1_valid", evt_valid, 0);
    read_cnt(2, 0, 1, "single");
    check("single_any_fail", any_fail, 1);
    step();
    check("lat_t2_valid", evt_valid, 1);
    check("lat_t2_id", evt_id, 2);
    check("lat_t2_ts", evt_ts, 5);
    wait_drain("single", 10, cyc);

    // three simultaneous fails delivered lowest index first
    drive_fail(4'b1011, 1);
    step();
    chk_fail = '0;
    wait_drain("multi", 20, cyc);
    check("multi_dropped", evt_dropped, 0);

    // overfill FIFO through pending bits, then drain at one per cycle
    evt_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      drive_fail(N'(1) << (k % N), 1);
      step();
    end
    chk_fail = '0;
    step();
    step();
    check("fill_valid", evt_valid, 1);
    check("fill_dropped", evt_dropped, 0);
    evt_ready = 1'b1;
    wait_drain("fill", 50, cyc);
    check("fill_drain_cycles", cyc, 12);
    check("fill_empty", evt_valid, 0);

    // two fails on checker 0 while full: second is lost
    do_clear();
    evt_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      drive_fail(N'(1) << (1 + k % 3), 1);
      step();
    end
    chk_fail = '0;
    step();
    step();
    drive_fail(4'b0001, 1);
    step();
    drive_fail(4'b0001, 0);
    step();
    chk_fail = '0;
    step();
    check("drop_flag", evt_dropped, 1);
    read_cnt(0, 0, 2, "drop");
    evt_ready = 1'b1;
    wait_drain("drop", 50, cyc);

    // pass and fail together: fail wins
    do_clear();
    evt_ready = 1'b0;
    chk_pass = 4'b0010;
    drive_fail(4'b0010, 1);
    step();
    chk_pass = '0;
    chk_fail = '0;
    read_cnt(1, 0, 1, "both");
    step();
    step();
    check("both_valid", evt_valid, 1);

    // clear overrides a same-cycle pass
    chk_pass = 4'b0010;
    do_clear();
    chk_pass = '0;
    read_cnt(1, 0, 0, "clear");
    check("clear_valid", evt_valid, 0);
    check("clear_any_fail", any_fail, 0);
    check("clear_dropped", evt_dropped, 0);

    // 17 passes into a 4-bit counter
    for (int k = 0; k < 17; k++) begin
      chk_pass = 4'b0001;
      step();
    end
    chk_pass = '0;
`ifdef ASSERTION_COLLECTOR_SATURATE_EN
    sat_exp = 4'd15;
`else
    sat_exp = 4'd1;
`endif
    read_cnt(0, sat_exp, 0, "wrap");

    // active count, one cycle late
    for (int k = 0; k < 6; k++) begin
      pat = N'($urandom_range(0, (1 << N) - 1));
      chk_active = pat;
      step();
      check("active_cnt", active_cnt, $countones(pat));
    end
    chk_active = '0;

    // mid-operation reset drops queued events
    evt_ready = 1'b0;
    drive_fail(4'b0100, 1);
    step();
    chk_fail = '0;
    step();
    step();
    check("pre_reset_valid", evt_valid, 1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_valid", evt_valid, 0);
    check("midrst_any_fail", any_fail, 0);
    read_cnt(2, 0, 0, "midrst");
    step();
    rst_n = 1'b1;
    step();
    check("end_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
